// File: rtl/sprite_evaluator_pkg.sv
// Shared types for sprite evaluation: OAM word layout, evaluator FSM states,
// secondary-array entry layout (also consumed by sprite_drawer) and the hit test.
package sprite_evaluator_pkg;

  localparam int SPRITE_HEIGHT = 16;
  localparam int OAM_ADDR_W    = 8;

  typedef struct packed {
    logic       enable;
    logic       yflip;
    logic       xflip;
    logic       prio;
    logic [9:0] ypos;
    logic [9:0] xpos;
    logic [7:0] spriteref;
  } oam_object_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } eval_state_t;

  typedef struct packed {
    logic [OAM_ADDR_W-1:0] addr;
    logic                  active;
  } second_entry_t;

  // All operands are 11 bits so ypos + height can never wrap back onto low lines.
  function automatic logic sprite_hits(input logic        obj_en,
                                       input logic [10:0] line,
                                       input logic [10:0] ypos,
                                       input logic [10:0] height);
    return obj_en && (line >= ypos) && (line < (ypos + height));
  endfunction

endpackage

// File: rtl/sprite_evaluator.sv
// Scans every OAM object once per requested line and collects, in address order,
// up to SECOND_ARRAY_SIZE objects that cover that line.
module sprite_evaluator #(
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int SPRITE_HEIGHT     = sprite_evaluator_pkg::SPRITE_HEIGHT,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           enable,
  output logic                                           done,
  output logic [OAM_ADDR_SIZE-1:0]                       oam_a,
  input  logic [OAM_DATA_SIZE-1:0]                       oam_d,
  input  logic [LINE_NUMBER_WIDTH-1:0]                   line_number,
  output logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]  second_array,
  output logic                                           overflow
);
  import sprite_evaluator_pkg::*;

  localparam int                 CNT_W   = $clog2(SECOND_ARRAY_SIZE + 1);
  localparam int                 SLOT_W  = $clog2(SECOND_ARRAY_SIZE);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SECOND_ARRAY_SIZE);

  eval_state_t                                   state_q;
  logic                                          done_q;
  logic                                          ovf_q;
  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] arr_q;
  logic [CNT_W-1:0]                              cnt_q;
  // One extra bit marks "every address has been issued".
  logic [OAM_ADDR_SIZE:0]                        idx_q;
  logic [OAM_ADDR_SIZE-1:0]                      a1_q;
  logic                                          v1_q;
  logic                                          last_q;
  logic [LINE_NUMBER_WIDTH-1:0]                  line_q;

  oam_object_t obj;
  logic        hit;
  logic        unused_obj_bits;

  assign obj = oam_object_t'(oam_d[31:0]);
  assign hit = sprite_hits(obj.enable, 11'(line_q), {1'b0, obj.ypos}, 11'(SPRITE_HEIGHT));
  assign unused_obj_bits = ^{obj.yflip, obj.xflip, obj.prio, obj.xpos, obj.spriteref, oam_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      arr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      a1_q    <= '0;
      v1_q    <= 1'b0;
      last_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            line_q  <= line_number;
            arr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            v1_q    <= 1'b0;
            last_q  <= 1'b0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            arr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            v1_q    <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            if (!idx_q[OAM_ADDR_SIZE]) begin
              a1_q  <= idx_q[OAM_ADDR_SIZE-1:0];
              v1_q  <= 1'b1;
              idx_q <= idx_q + (OAM_ADDR_SIZE+1)'(1);
            end else begin
              v1_q <= 1'b0;
            end
            if (v1_q && hit) begin
              if (cnt_q < CNT_MAX) begin
                arr_q[cnt_q[SLOT_W-1:0]] <= {a1_q, 1'b1};
                cnt_q                    <= cnt_q + CNT_W'(1);
              end else begin
                ovf_q <= 1'b1;
              end
            end
            // Settle one cycle after the final write so done lands 2^N+2 after start.
            last_q <= v1_q && (a1_q == '1);
            if (last_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The OAM bus is shared with sprite_drawer, so it is only driven while scanning.
  assign oam_a = (state_q == ST_SCAN)
               ? (idx_q[OAM_ADDR_SIZE] ? '1 : idx_q[OAM_ADDR_SIZE-1:0])
               : 'z;

  assign done         = done_q;
  assign overflow     = ovf_q;
  assign second_array = arr_q;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Bench for sprite_evaluator: directed vector table, hand-written corner sequences
// and randomized OAM contents checked against a line-coverage reference model.
module tb_sprite_evaluator;

  localparam int AW = 8;
  localparam int SA = 32;
  localparam int LW = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   done;
  wire  [AW-1:0]          oam_a;
  logic [31:0]            oam_d;
  logic [LW-1:0]          line_number;
  logic [SA-1:0][AW:0]    second_array;
  logic                   overflow;

  sprite_evaluator dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .done         (done),
    .oam_a        (oam_a),
    .oam_d        (oam_d),
    .line_number  (line_number),
    .second_array (second_array),
    .overflow     (overflow)
  );

  // clock / OAM model
  always #5 clk = ~clk;

  logic [31:0] oam_mem [256];
  always @(posedge clk) oam_d <= oam_mem[oam_a];

  int         total = 0;
  int         bad   = 0;
  logic [AW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [31:0] make_obj(input logic en, input int ypos);
    logic [31:0] w;
    w = $urandom;
    w[31] = en;
    w[27:18] = ypos[9:0];
    return w;
  endfunction

  task automatic clear_oam();
    for (int a = 0; a < 256; a++) oam_mem[a] = make_obj(1'b0, $urandom_range(0, 1023));
  endtask

  // reference: every enabled object whose 16-line band covers the line, in address order
  task automatic build_expected(input int line);
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      int y;
      logic [7:0] addr;
      y = int'(oam_mem[a][27:18]);
      addr = a[7:0];
      if (oam_mem[a][31] && line >= y && line < y + 16) exp_q.push_back({addr, 1'b1});
    end
  endtask

  task automatic check_results(input string name, input int line);
    build_expected(line);
    for (int i = 0; i < SA; i++) begin
      logic [AW:0] e;
      e = (i < exp_q.size()) ? exp_q[i] : '0;
      check($sformatf("%s entry%0d", name, i), 32'(second_array[i]), 32'(e));
    end
    check($sformatf("%s overflow", name), 32'(overflow), 32'(exp_q.size() > SA));
  endtask

  // driver: start a scan, optionally change line_number mid-scan, wait for done
  task automatic run_scan(input int line, input int change_at, input int new_line, input string name);
    int n;
    line_number = LW'(line);
    enable = 1'b1;
    @(posedge clk); #1;
    check({name, " oam_a start"}, 32'(oam_a), 32'd0);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) check({name, " oam_a step"}, 32'(oam_a), 32'd5);
      if (n == change_at) line_number = LW'(new_line);
    end
    check({name, " done latency"}, 32'(n), 32'd258);
  endtask

  task automatic drop_enable(input string name);
    enable = 1'b0;
    @(posedge clk); #1;
    check({name, " done low"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    int   line;
    int   addr;
    int   ypos;
    logic en;
    logic hit;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{line: 100, addr: 10,  ypos: 100,  en: 1'b1, hit: 1'b1};
    vecs[1] = '{line: 115, addr: 20,  ypos: 100,  en: 1'b1, hit: 1'b1};
    vecs[2] = '{line: 116, addr: 30,  ypos: 100,  en: 1'b1, hit: 1'b0};
    vecs[3] = '{line: 99,  addr: 40,  ypos: 100,  en: 1'b1, hit: 1'b0};
    vecs[4] = '{line: 0,   addr: 5,   ypos: 1020, en: 1'b1, hit: 1'b0};
    vecs[5] = '{line: 100, addr: 50,  ypos: 95,   en: 1'b0, hit: 1'b0};
    vecs[6] = '{line: 479, addr: 255, ypos: 470,  en: 1'b1, hit: 1'b1};
    vecs[7] = '{line: 0,   addr: 0,   ypos: 0,    en: 1'b1, hit: 1'b1};

    // reset block
    rst = 1'b1;
    enable = 1'b0;
    line_number = '0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    check("reset done", 32'(done), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset array", 32'(|second_array), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed vector table
    for (int v = 0; v < 8; v++) begin
      logic [7:0] a8;
      clear_oam();
      oam_mem[vecs[v].addr] = make_obj(vecs[v].en, vecs[v].ypos);
      a8 = vecs[v].addr[7:0];
      run_scan(vecs[v].line, -1, 0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d entry0", v), 32'(second_array[0]), vecs[v].hit ? 32'({a8, 1'b1}) : 32'd0);
      check($sformatf("vec%0d entry1", v), 32'(second_array[1]), 32'd0);
      check($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
      drop_enable($sformatf("vec%0d", v));
    end

    // three objects around line 100
    clear_oam();
    oam_mem[3] = make_obj(1'b1, 90);
    oam_mem[7] = make_obj(1'b1, 100);
    oam_mem[9] = make_obj(1'b1, 116);
    run_scan(100, -1, 0, "basic");
    check("basic entry0", 32'(second_array[0]), 32'd7);
    check("basic entry1", 32'(second_array[1]), 32'd15);
    check_results("basic", 100);
    drop_enable("basic");

    // 40 objects on the line: overflow, hold in DONE, retention after leaving DONE
    clear_oam();
    for (int a = 0; a < 40; a++) oam_mem[a] = make_obj(1'b1, 100);
    run_scan(105, -1, 0, "ovf");
    check("ovf entry31", 32'(second_array[31]), 32'd63);
    check("ovf flag", 32'(overflow), 32'd1);
    check_results("ovf", 105);
    line_number = LW'(7);
    repeat (5) @(posedge clk);
    #1;
    check("hold done", 32'(done), 32'd1);
    check("hold entry31", 32'(second_array[31]), 32'd63);
    drop_enable("ovf");
    check("retain overflow", 32'(overflow), 32'd1);
    check("retain entry0", 32'(second_array[0]), 32'd1);

    // abort at cycle 100 of SCAN, then restart
    clear_oam();
    oam_mem[3] = make_obj(1'b1, 90);
    oam_mem[7] = make_obj(1'b1, 100);
    line_number = LW'(100);
    enable = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort done", 32'(done), 32'd0);
    check("abort array", 32'(|second_array), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort stays idle", 32'(done), 32'd0);
    run_scan(100, -1, 0, "restart");
    check_results("restart", 100);
    drop_enable("restart");

    // line_number change mid-scan is ignored
    run_scan(100, 50, 200, "linechg");
    check_results("linechg", 100);
    drop_enable("linechg");

    // reset mid-scan
    line_number = LW'(100);
    enable = 1'b1;
    @(posedge clk);
    repeat (80) @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("midrst done", 32'(done), 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    check("midrst array", 32'(|second_array), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_scan(100, -1, 0, "postrst");
    check_results("postrst", 100);
    drop_enable("postrst");

    // randomized OAM contents
    for (int r = 0; r < 6; r++) begin
      int line;
      int w;
      line = $urandom_range(0, 479);
      w = (r % 3 == 0) ? 20 : ((r % 3 == 1) ? 200 : 600);
      for (int a = 0; a < 256; a++) begin
        int y;
        y = line + $urandom_range(0, 2 * w) - w;
        if (y < 0) y = (a % 2 == 0) ? 0 : 1023 - $urandom_range(0, 20);
        if (y > 1023) y = 1023;
        oam_mem[a] = make_obj($urandom_range(0, 3) != 0, y);
      end
      run_scan(line, -1, 0, $sformatf("rand%0d", r));
      check_results($sformatf("rand%0d", r), line);
      drop_enable($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
